// File: rtl/mem_stream_reader.sv
// Sequential SRAM reader feeding a valid/ready stream through a
// 2-entry credit-managed output buffer.
module mem_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic [ADDR_WIDTH-1:0] cmdAddrIn,
  input  logic [LEN_WIDTH-1:0]  cmdLenIn,
  input  logic                  cmdValidIn,
  output logic                  cmdReadyOut,
  output logic [ADDR_WIDTH-1:0] memAddrOut,
  output logic                  memRdEnOut,
  input  logic [DATA_WIDTH-1:0] memDataIn,
  output logic [DATA_WIDTH-1:0] rdDataOut,
  output logic                  rdValidOut,
  input  logic                  rdReadyIn,
  output logic                  rdLastOut,
  output logic                  busyOut,
  output logic                  doneOut
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  issued_q, issued_d;
  logic [LEN_WIDTH-1:0]  popped_q, popped_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic [1:0] lvl;

  assign cmdReadyOut = (state_q == IDLE);
  assign busyOut     = (state_q != IDLE);
  assign doneOut     = (state_q == DONE);
  assign memAddrOut  = addr_q;
  assign memRdEnOut  = issue;
  assign rdValidOut  = (cnt_q != 2'd0);
  assign rdDataOut   = buf0_q;
  assign rdLastOut   = rdValidOut &&
                       (popped_q == len_q - LEN_WIDTH'(1));

  // Occupancy after this cycle's pop, counting the read still in flight
  assign pop   = rdValidOut & rdReadyIn;
  assign push  = inflight_q;
  assign occ   = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue = (state_q == READ) && (issued_q != len_q) &&
                 (occ < 3'd2);
  assign lvl   = cnt_q - {1'b0, pop};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    issued_d = issued_q;
    popped_d = popped_q;
    cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
    buf0_d   = buf0_q;
    buf1_d   = buf1_q;

    if (pop) buf0_d = buf1_q;
    if (push) begin
      if (lvl == 2'd0) buf0_d = memDataIn;
      else             buf1_d = memDataIn;
    end
    if (pop) popped_d = popped_q + LEN_WIDTH'(1);
    if (issue) begin
      addr_d   = addr_q + ADDR_WIDTH'(1);
      issued_d = issued_q + LEN_WIDTH'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (cmdValidIn) begin
          addr_d   = cmdAddrIn;
          len_d    = cmdLenIn;
          issued_d = '0;
          popped_d = '0;
          state_d  = (cmdLenIn == '0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue && (issued_q + LEN_WIDTH'(1) == len_q))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (!inflight_q && (cnt_d == 2'd0)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn) begin
    if (!rstIn) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      popped_q   <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      popped_q   <= popped_d;
      cnt_q      <= cnt_d;
      inflight_q <= issue;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader with a 1-cycle SRAM model
// returning data equal to the read address.
module tb_mem_stream_reader;

  logic        clkIn = 1'b0;
  logic        rstIn;
  logic [15:0] cmdAddrIn;
  logic [15:0] cmdLenIn;
  logic        cmdValidIn;
  logic        cmdReadyOut;
  logic [15:0] memAddrOut;
  logic        memRdEnOut;
  logic [31:0] memDataIn = '0;
  logic [31:0] rdDataOut;
  logic        rdValidOut;
  logic        rdReadyIn;
  logic        rdLastOut;
  logic        busyOut;
  logic        doneOut;

  int total = 0;
  int bad   = 0;

  mem_stream_reader dut (
    .clkIn       (clkIn),
    .rstIn       (rstIn),
    .cmdAddrIn   (cmdAddrIn),
    .cmdLenIn    (cmdLenIn),
    .cmdValidIn  (cmdValidIn),
    .cmdReadyOut (cmdReadyOut),
    .memAddrOut  (memAddrOut),
    .memRdEnOut  (memRdEnOut),
    .memDataIn   (memDataIn),
    .rdDataOut   (rdDataOut),
    .rdValidOut  (rdValidOut),
    .rdReadyIn   (rdReadyIn),
    .rdLastOut   (rdLastOut),
    .busyOut     (busyOut),
    .doneOut     (doneOut)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn)
    memDataIn <= memRdEnOut ? {16'h0, memAddrOut} : 32'h0;

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  task automatic test_reset();
    rstIn      = 1'b0;
    cmdValidIn = 1'b0;
    cmdAddrIn  = '0;
    cmdLenIn   = '0;
    rdReadyIn  = 1'b0;
    tick();
    tick();
    #1;
    total++;
    if ({cmdReadyOut, memRdEnOut, rdValidOut, rdLastOut, busyOut,
         doneOut} !== 6'b100000) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=100000",
               {cmdReadyOut, memRdEnOut, rdValidOut, rdLastOut,
                busyOut, doneOut});
    end
    total++;
    if (memAddrOut !== 16'h0 || rdDataOut !== 32'h0) begin
      bad++;
      $display("FAIL reset_data addr=%h data=%h want 0/0",
               memAddrOut, rdDataOut);
    end
    rstIn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    rdReadyIn  = 1'b1;
    cmdAddrIn  = 16'h0010;
    cmdLenIn   = 16'd4;
    cmdValidIn = 1'b1;
    #1;
    total++;
    if (cmdReadyOut !== 1'b1) begin
      bad++;
      $display("FAIL basic_ready got=%b want=1", cmdReadyOut);
    end
    tick();
    cmdValidIn = 1'b0;
    for (int k = 0; k < 8; k++) begin
      logic ev;
      #1;
      ev = (k >= 2 && k <= 5);
      if (k == 0) begin
        total++;
        if (memRdEnOut !== 1'b1 || memAddrOut !== 16'h0010) begin
          bad++;
          $display("FAIL basic_first_rd en=%b addr=%h want 1/0010",
                   memRdEnOut, memAddrOut);
        end
      end
      total++;
      if (rdValidOut !== ev) begin
        bad++;
        $display("FAIL basic_valid k=%0d got=%b want=%b",
                 k, rdValidOut, ev);
      end
      if (ev) begin
        total++;
        if (rdDataOut !== 32'(16'h0010 + k - 2) ||
            rdLastOut !== (k == 5)) begin
          bad++;
          $display("FAIL basic_word k=%0d data=%h last=%b",
                   k, rdDataOut, rdLastOut);
        end
      end
      total++;
      if (doneOut !== (k == 6)) begin
        bad++;
        $display("FAIL basic_done k=%0d got=%b want=%b",
                 k, doneOut, (k == 6));
      end
      if (k == 7) begin
        total++;
        if (cmdReadyOut !== 1'b1) begin
          bad++;
          $display("FAIL basic_ready_back got=%b want=1",
                   cmdReadyOut);
        end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] pat;
    logic [31:0] prev_data;
    logic        prev_stall;
    logic        seen_done;
    int          n;
    int          strobes;
    int          pops;
    pat        = 64'hB38D_5A61_C4E2_97F0;
    prev_stall = 1'b0;
    prev_data  = '0;
    seen_done  = 1'b0;
    n          = 0;
    strobes    = 0;
    pops       = 0;
    rdReadyIn  = 1'b0;
    cmdAddrIn  = 16'h0100;
    cmdLenIn   = 16'd8;
    cmdValidIn = 1'b1;
    tick();
    cmdValidIn = 1'b0;
    for (int i = 0; i < 200 && !seen_done; i++) begin
      rdReadyIn = pat[i % 64];
      #1;
      total++;
      if (strobes - pops > 2) begin
        bad++;
        $display("FAIL bp_credit outstanding=%0d want<=2",
                 strobes - pops);
      end
      if (prev_stall) begin
        total++;
        if (rdValidOut !== 1'b1 || rdDataOut !== prev_data) begin
          bad++;
          $display("FAIL bp_hold v=%b data=%h want 1/%h",
                   rdValidOut, rdDataOut, prev_data);
        end
      end
      if (memRdEnOut) begin
        total++;
        if (memAddrOut !== 16'(16'h0100 + strobes)) begin
          bad++;
          $display("FAIL bp_addr got=%h want=%h",
                   memAddrOut, 16'(16'h0100 + strobes));
        end
        strobes++;
      end
      if (rdValidOut && rdReadyIn) begin
        total++;
        if (rdDataOut !== 32'(16'h0100 + n) ||
            rdLastOut !== (n == 7)) begin
          bad++;
          $display("FAIL bp_word n=%0d data=%h last=%b",
                   n, rdDataOut, rdLastOut);
        end
        n++;
        pops++;
      end
      if (doneOut) seen_done = 1'b1;
      prev_stall = rdValidOut && !rdReadyIn;
      prev_data  = rdDataOut;
      tick();
    end
    total++;
    if (!seen_done || n != 8) begin
      bad++;
      $display("FAIL bp_count words=%0d done=%b want 8/1",
               n, seen_done);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [4];
    int          s;
    logic        seen_done;
    exp_a      = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    s          = 0;
    seen_done  = 1'b0;
    rdReadyIn  = 1'b1;
    cmdAddrIn  = 16'hFFFE;
    cmdLenIn   = 16'd4;
    cmdValidIn = 1'b1;
    tick();
    cmdValidIn = 1'b0;
    for (int i = 0; i < 30 && !seen_done; i++) begin
      #1;
      if (memRdEnOut) begin
        total++;
        if (s > 3 || memAddrOut !== exp_a[s & 3]) begin
          bad++;
          $display("FAIL wrap_addr idx=%0d got=%h want=%h",
                   s, memAddrOut, exp_a[s & 3]);
        end
        s++;
      end
      if (doneOut) seen_done = 1'b1;
      tick();
    end
    total++;
    if (s != 4 || !seen_done) begin
      bad++;
      $display("FAIL wrap_count reads=%0d done=%b want 4/1",
               s, seen_done);
    end
  endtask

  task automatic test_zero_len();
    cmdAddrIn  = 16'h0055;
    cmdLenIn   = 16'd0;
    cmdValidIn = 1'b1;
    tick();
    cmdValidIn = 1'b0;
    #1;
    total++;
    if ({doneOut, memRdEnOut, rdValidOut} !== 3'b100) begin
      bad++;
      $display("FAIL zero_done done/rd/v got=%b want=100",
               {doneOut, memRdEnOut, rdValidOut});
    end
    tick();
    #1;
    total++;
    if ({cmdReadyOut, doneOut, memRdEnOut} !== 3'b100) begin
      bad++;
      $display("FAIL zero_idle rdy/done/rd got=%b want=100",
               {cmdReadyOut, doneOut, memRdEnOut});
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int   pops;
    int   n;
    logic seen_done;
    pops       = 0;
    rdReadyIn  = 1'b1;
    cmdAddrIn  = 16'h0200;
    cmdLenIn   = 16'd16;
    cmdValidIn = 1'b1;
    tick();
    cmdValidIn = 1'b0;
    for (int i = 0; i < 30 && pops < 5; i++) begin
      #1;
      if (rdValidOut && rdReadyIn) pops++;
      tick();
    end
    total++;
    if (pops != 5) begin
      bad++;
      $display("FAIL mr_prefill pops=%0d want=5", pops);
    end
    rstIn = 1'b0;
    tick();
    rstIn = 1'b1;
    #1;
    total++;
    if ({cmdReadyOut, memRdEnOut, rdValidOut, rdLastOut, busyOut,
         doneOut} !== 6'b100000 ||
        memAddrOut !== 16'h0 || rdDataOut !== 32'h0) begin
      bad++;
      $display("FAIL mr_reset ctrl=%b addr=%h data=%h",
               {cmdReadyOut, memRdEnOut, rdValidOut, rdLastOut,
                busyOut, doneOut}, memAddrOut, rdDataOut);
    end
    tick();
    #1;
    total++;
    if (rdValidOut !== 1'b0) begin
      bad++;
      $display("FAIL mr_stale got=%b want=0", rdValidOut);
    end
    cmdAddrIn  = 16'h0040;
    cmdLenIn   = 16'd2;
    cmdValidIn = 1'b1;
    tick();
    cmdValidIn = 1'b0;
    n         = 0;
    seen_done = 1'b0;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      #1;
      if (rdValidOut && rdReadyIn) begin
        total++;
        if (rdDataOut !== 32'(16'h0040 + n)) begin
          bad++;
          $display("FAIL mr_word n=%0d got=%h want=%h",
                   n, rdDataOut, 32'(16'h0040 + n));
        end
        n++;
      end
      if (doneOut) seen_done = 1'b1;
      tick();
    end
    total++;
    if (n != 2 || !seen_done) begin
      bad++;
      $display("FAIL mr_count words=%0d done=%b want 2/1",
               n, seen_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ca [3];
    logic [15:0] cl [3];
    logic [15:0] ew [6];
    int          idx;
    int          dones;
    int          n;
    int          low;
    ca    = '{16'h0300, 16'h0310, 16'h0320};
    cl    = '{16'd2, 16'd1, 16'd3};
    ew    = '{16'h0300, 16'h0301, 16'h0310,
              16'h0320, 16'h0321, 16'h0322};
    idx   = 0;
    dones = 0;
    n     = 0;
    low   = 0;
    rdReadyIn = 1'b1;
    for (int i = 0; i < 100 && dones < 3; i++) begin
      cmdValidIn = (idx < 3);
      cmdAddrIn  = ca[idx % 3];
      cmdLenIn   = cl[idx % 3];
      #1;
      total++;
      if (cmdReadyOut !== !busyOut) begin
        bad++;
        $display("FAIL b2b_ready_idle rdy=%b busy=%b",
                 cmdReadyOut, busyOut);
      end
      if (!busyOut) low++;
      else begin
        if (low != 0 && idx > 0 && idx < 3) begin
          total++;
          if (low != 1) begin
            bad++;
            $display("FAIL b2b_gap low_cycles=%0d want=1", low);
          end
        end
        low = 0;
      end
      if (rdValidOut && rdReadyIn) begin
        total++;
        if (n > 5 || rdDataOut !== {16'h0, ew[n % 6]}) begin
          bad++;
          $display("FAIL b2b_word n=%0d got=%h want=%h",
                   n, rdDataOut, ew[n % 6]);
        end
        n++;
      end
      if (doneOut) dones++;
      if (cmdReadyOut && cmdValidIn) idx++;
      tick();
    end
    cmdValidIn = 1'b0;
    total++;
    if (dones != 3 || n != 6 || idx != 3) begin
      bad++;
      $display("FAIL b2b_count done=%0d words=%0d cmds=%0d want 3/6/3",
               dones, n, idx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_len();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
